des_round_ctrl: RTL and testbench

//  Iterative DES engine controller: sequences one shared f_function instance over 16 rounds, one round per clock.

---
 rtl/des_round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_des_round_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// Iterative DES controller: runs one external combinational f_function over ROUNDS
// rounds (one per clock), holding the L/R halves, the C/D key schedule and the handshakes.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter bit USE_IP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic [31:0] f_R,
  output logic [47:0] f_key,
  input  logic [31:0] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, with data_out frozen meanwhile.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10,
                                23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};

  // Table entries are DES bit numbers: DES bit 1 is the MSB of each vector.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  state_t      r_state, w_state_next;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d, w_c_next, w_d_next;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic [63:0] r_data_out;
  logic        w_accept, w_last, w_one;
  logic [31:0] w_l_new;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_ROUND) && (r_cnt == LAST);
  assign w_l_new  = r_l ^ f_out;

  // Decrypt walks the encrypt schedule backwards: at step k it undoes the shift of
  // encrypt round 17-k, which is a single bit for k = 1, 8, 15 and none at k = 0.
  always_comb begin
    w_c_next = r_c;
    w_d_next = r_d;
    w_one    = 1'b0;
    if (!r_dec) begin
      w_one = (r_cnt == 4'd0) || (r_cnt == 4'd1) || (r_cnt == 4'd8) || (r_cnt == 4'd15);
      if (w_one) begin
        w_c_next = {r_c[26:0], r_c[27]};
        w_d_next = {r_d[26:0], r_d[27]};
      end else begin
        w_c_next = {r_c[25:0], r_c[27:26]};
        w_d_next = {r_d[25:0], r_d[27:26]};
      end
    end else if (r_cnt != 4'd0) begin
      w_one = (r_cnt == 4'd1) || (r_cnt == 4'd8) || (r_cnt == 4'd15);
      if (w_one) begin
        w_c_next = {r_c[0], r_c[27:1]};
        w_d_next = {r_d[0], r_d[27:1]};
      end else begin
        w_c_next = {r_c[1:0], r_c[27:2]};
        w_d_next = {r_d[1:0], r_d[27:2]};
      end
    end
  end

  assign f_R   = r_r;
  assign f_key = perm_pc2({w_c_next, w_d_next});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_dec      <= 1'b0;
      r_data_out <= '0;
    end else if (w_accept) begin
      {r_l, r_r} <= USE_IP ? perm_ip(data_in) : data_in;
      {r_c, r_d} <= perm_pc1(key_in);
      r_dec      <= decrypt;
      r_cnt      <= '0;
    end else if (r_state == S_ROUND) begin
      r_l <= r_r;
      r_r <= w_l_new;
      r_c <= w_c_next;
      r_d <= w_d_next;
      if (w_last) begin
        // The final round is not swapped: the block leaves as {R16, L16}.
        r_data_out <= USE_IP ? perm_fp({w_l_new, r_r}) : {w_l_new, r_r};
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign data_out    = r_data_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: supplies the f_function model, drives blocks
// through the handshake and scores results against hand-computed DES vectors.
module tb_des_round_ctrl;

  logic        clk, rst_n, in_valid, in_ready, decrypt, out_valid, out_ready, busy;
  logic [63:0] data_in, key_in, data_out;
  logic [31:0] f_R, f_out;
  logic [47:0] f_key;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  des_round_ctrl #(.ROUNDS(16), .USE_IP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .decrypt(decrypt), .data_in(data_in), .key_in(key_in),
    .f_R(f_R), .f_key(f_key), .f_out(f_out),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- f_function model (E, S1-S8, P) ----------------
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, y;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47 - 6 * j -: 6];
      idx = 16 * int'({b[5], b[0]}) + int'(b[4:1]);
      s[31 - 4 * j -: 4] = 4'(S_T[j][idx]);
    end
    for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
    return y;
  endfunction

  always_comb f_out = f_model(f_R, f_key);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] k, input logic [63:0] d, input logic dec);
    int guard;
    @(negedge clk);
    key_in   = k;
    data_in  = d;
    decrypt  = dec;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the inputs: only the accept edge may matter.
    key_in   = {$urandom, $urandom};
    data_in  = {$urandom, $urandom};
    decrypt  = ~dec;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid is seen.
  task automatic wait_valid(input string tag, input bit chk, output logic [63:0] res);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    res = data_out;
    if (chk) begin
      if (exp_q.size() == 0) check({tag, "_no_exp"}, 64'd0, 64'd1);
      else check(tag, data_out, exp_q.pop_front());
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [63:0] res, held, k, p;
  bit          rdy;
  int          n_acc, n_out;
  int          acc_t[4];
  int          out_t[4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
    data_in = '0; key_in = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_f_R", 64'(f_R), 64'd0);
    check("rst_f_key", 64'(f_key), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Vector 1 encrypt, then decrypt back.
    send(K1, P1, 1'b0);
    check("round_busy", 64'(busy), 64'd1);
    check("round_in_ready", 64'(in_ready), 64'd0);
    exp_q.push_back(C1);
    wait_valid("enc_v1", 1'b1, res);
    release_out();
    check("after_out_valid", 64'(out_valid), 64'd0);
    send(K1, C1, 1'b1);
    exp_q.push_back(P1);
    wait_valid("dec_v1", 1'b1, res);
    release_out();

    // Back-pressure in DONE with in_valid pulses that must be ignored.
    send(K2, P2, 1'b0);
    exp_q.push_back(C2);
    wait_valid("enc_v2", 1'b1, held);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      data_in  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_data_out", data_out, C2);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    check("released_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("no_queued_block", 64'(busy), 64'd0);

    // Put a nonzero value in data_out, then abort a block mid-run with reset.
    send(K1, P1, 1'b0);
    exp_q.push_back(C1);
    wait_valid("enc_pre_rst", 1'b1, res);
    release_out();
    send(K1, P1, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_data_out", data_out, 64'd0);
    check("abort_f_R", 64'(f_R), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_in_ready", 64'(in_ready), 64'd1);
    send(K1, P1, 1'b0);
    exp_q.push_back(C1);
    wait_valid("enc_after_rst", 1'b1, res);
    release_out();

    // Back-to-back: in_valid and out_ready held high.
    @(negedge clk);
    key_in = K1; data_in = P1; decrypt = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(C1);
    exp_q.push_back(C2);
    n_acc = 0; n_out = 0;
    acc_t = '{default: 0};
    out_t = '{default: 0};
    for (int c = 0; c < 60; c++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && in_valid) begin
        if (n_acc < 4) acc_t[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          key_in = K2; data_in = P2;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (n_out < 4) out_t[n_out] = c;
        n_out++;
        if (exp_q.size() == 0) check("b2b_extra_result", data_out, 64'd0 - 64'd1);
        else check("b2b_data", data_out, exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd2);
    check("b2b_results", 64'(n_out), 64'd2);
    check("b2b_latency", 64'(out_t[0] - acc_t[0]), 64'd16);
    check("b2b_accept_spacing", 64'(acc_t[1] - acc_t[0]), 64'd18);
    check("b2b_result_spacing", 64'(out_t[1] - out_t[0]), 64'd18);

    // Random round trips.
    for (int it = 0; it < 1000; it++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      send(k, p, 1'b0);
      wait_valid("rnd_enc", 1'b0, res);
      release_out();
      send(k, res, 1'b1);
      exp_q.push_back(p);
      wait_valid("rnd_dec", 1'b1, res);
      release_out();
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
